// File: rtl/mem_copy_engine_if.sv
// Interface bundling the mem_copy_engine command handshake and its memory bus.
// The engine uses the master modport (it initiates memory accesses); the host/memory
// side uses slave. Optional MEM_COPY_FILL_EN adds the fill_mode/fill_value request fields.
interface mem_copy_engine_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  // Command side
  logic                  start;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH-1:0] length;
`ifdef MEM_COPY_FILL_EN
  logic                  fill_mode;
  logic [DATA_WIDTH-1:0] fill_value;
`endif
  logic                  busy;
  logic                  done;
  // Memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  start, src_addr, dst_addr, length, mem_rdata,
`ifdef MEM_COPY_FILL_EN
    input  fill_mode, fill_value,
`endif
    output busy, done, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output start, src_addr, dst_addr, length, mem_rdata,
`ifdef MEM_COPY_FILL_EN
    output fill_mode, fill_value,
`endif
    input  busy, done, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Memory copy engine: copies length bytes from src_addr to dst_addr in ascending order,
// one READ cycle then one WRITE cycle per byte, pointers wrapping modulo 2^ADDR_WIDTH.
// Build option MEM_COPY_FILL_EN adds a fill mode that writes fill_value once per cycle.
// All outputs are registers; nothing is combinational from an input.
module mem_copy_engine #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  mem_copy_engine_if.master io_bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_we;
  logic                  r_fill;

  logic                  w_fill_req;
  logic [DATA_WIDTH-1:0] w_fill_val;

`ifdef MEM_COPY_FILL_EN
  assign w_fill_req = io_bus.fill_mode;
  assign w_fill_val = io_bus.fill_value;
`else
  assign w_fill_req = 1'b0;
  assign w_fill_val = '0;
`endif

  // Transfer FSM; outputs are computed for the state being entered so they stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_buf      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_we   <= 1'b0;
      r_fill     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_src  <= io_bus.src_addr;
            r_dst  <= io_bus.dst_addr;
            r_cnt  <= io_bus.length;
            r_fill <= w_fill_req;
            if (w_fill_req) begin
              r_buf <= w_fill_val;
            end
            if (io_bus.length == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else if (w_fill_req) begin
              r_state    <= StWrite;
              r_busy     <= 1'b1;
              r_mem_addr <= io_bus.dst_addr;
              r_mem_we   <= 1'b1;
            end else begin
              r_state    <= StRead;
              r_busy     <= 1'b1;
              r_mem_addr <= io_bus.src_addr;
            end
          end
        end
        StRead: begin
          r_buf      <= io_bus.mem_rdata;
          r_state    <= StWrite;
          r_mem_addr <= r_dst;
          r_mem_we   <= 1'b1;
        end
        StWrite: begin
          r_src <= r_src + AddrOne;
          r_dst <= r_dst + AddrOne;
          r_cnt <= r_cnt - AddrOne;
          if (r_cnt == AddrOne) begin
            r_state    <= StDone;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
          end else if (r_fill) begin
            // Fill streams one byte per cycle without a READ.
            r_mem_addr <= r_dst + AddrOne;
          end else begin
            r_state    <= StRead;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_src + AddrOne;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_buf;
  assign io_bus.mem_we    = r_mem_we;

endmodule
